// File: rtl/pc_sequencer.sv
// Multicycle next-PC controller for MulCPU: owns the PC register, the
// IF/ID/EXE/MEM/WB state machine and the retired-instruction counter.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  HALT_OP  = 6'b111111
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic [31:0] rs_data,
  input  logic        zero,
  input  logic        imem_ready,
  output logic        fetch_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        ra_write,
  output logic [31:0] ra_data,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic        retire;
  logic [31:0] jump_target;
  logic [31:0] branch_target;
  logic        branch_taken;

  assign jump_target   = {pc_q[31:28], addr26, 2'b00};
  assign branch_target = pc_q + {{14{imm16[15]}}, imm16, 2'b00};
  assign branch_taken  = (opcode == OP_BEQ) ? zero : ~zero;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retire    = 1'b0;
    fetch_req = 1'b0;
    ir_write  = 1'b0;
    ra_write  = 1'b0;
    case (state_q)
      S_IF: begin
        fetch_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          pc_d     = pc_q + 32'd4;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        if (opcode == OP_J || opcode == OP_JAL) begin
          pc_d     = jump_target;
          ra_write = (opcode == OP_JAL);
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (opcode == OP_RTYPE && funct == FN_JR) begin
          pc_d    = rs_data;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (opcode == HALT_OP) begin
          retire  = 1'b1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (opcode == OP_BEQ || opcode == OP_BNE) begin
          if (branch_taken) pc_d = branch_target;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          retire  = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_d = S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    retired_d = retired_q + {31'd0, retire};
  end

  // A jump or taken branch onto the current PC is not reported as an update
  assign pc_write = (pc_d != pc_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IF;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
    end
  end

  assign pc      = pc_q;
  assign ra_data = pc_q;
  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; one task per scenario.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] addr26 = 26'd0;
  logic [31:0] rs_data = 32'd0;
  logic        zero = 1'b0;
  logic        imem_ready = 1'b0;
  logic        fetch_req, ir_write, pc_write, ra_write, halted;
  logic [31:0] ra_data, pc, retired;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .funct(funct), .imm16(imm16),
    .addr26(addr26), .rs_data(rs_data), .zero(zero), .imem_ready(imem_ready),
    .fetch_req(fetch_req), .ir_write(ir_write), .pc_write(pc_write),
    .ra_write(ra_write), .ra_data(ra_data), .pc(pc), .state(state),
    .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic [15:0] imm, input logic [25:0] addr,
                           input logic [31:0] rs);
    opcode = op; funct = fn; imm16 = imm; addr26 = addr; rs_data = rs;
  endtask

  // jr to an arbitrary PC: two cycles, one retirement
  task automatic goto_pc(input logic [31:0] target);
    set_instr(6'b000000, 6'b001000, 16'd0, 26'd0, target);
    imem_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    imem_ready = 1'b0;
    do_reset();
    #1;
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    checks++; if (retired !== 32'd0) begin errors++; $display("[TB] FAIL reset_retired: got %0d expected 0", retired); end
    checks++; if ({fetch_req, ir_write, pc_write, ra_write, halted} !== 5'b10000) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b expected 10000", {fetch_req, ir_write, pc_write, ra_write, halted});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++; if ({pc, state, fetch_req, ir_write, pc_write} !== {32'h0, 3'd0, 3'b100}) begin
        errors++; $display("[TB] FAIL wait_hold%0d: got pc=%h st=%0d fr/ir/pw=%b%b%b expected pc=0 st=0 100", i, pc, state, fetch_req, ir_write, pc_write);
      end
    end
    set_instr(6'b000000, 6'b100000, 16'd0, 26'd0, 32'd0);
    imem_ready = 1'b1;
    #1;
    checks++; if ({ir_write, pc_write} !== 2'b11) begin errors++; $display("[TB] FAIL ready_strobes: got %b expected 11", {ir_write, pc_write}); end
    tick();
    checks++; if ({pc, state} !== {32'h4, 3'd1}) begin errors++; $display("[TB] FAIL fetch_done: got pc=%h st=%0d expected pc=4 st=1", pc, state); end
  endtask

  task automatic test_jump();
    do_reset();
    goto_pc(32'h4000_0000);
    set_instr(6'b000010, 6'd0, 16'd0, 26'h0000100, 32'd0);
    tick();
    #1;
    checks++; if ({pc, ra_write, pc_write} !== {32'h4000_0004, 2'b01}) begin
      errors++; $display("[TB] FAIL j_id: got pc=%h ra_write=%b pc_write=%b expected 40000004 0 1", pc, ra_write, pc_write);
    end
    tick();
    // retirements: the jr used to reach 0x4000_0000, then the j
    checks++; if ({pc, retired, state} !== {32'h4000_0400, 32'd2, 3'd0}) begin
      errors++; $display("[TB] FAIL j_done: got pc=%h ret=%0d st=%0d expected 40000400 2 0", pc, retired, state);
    end
    do_reset();
    goto_pc(32'h4000_0000);
    set_instr(6'b000011, 6'd0, 16'd0, 26'h0000100, 32'd0);
    #1;
    checks++; if (ra_write !== 1'b0) begin errors++; $display("[TB] FAIL jal_if_ra: got %b expected 0", ra_write); end
    tick();
    #1;
    checks++; if ({ra_write, ra_data} !== {1'b1, 32'h4000_0004}) begin
      errors++; $display("[TB] FAIL jal_link: got ra_write=%b ra_data=%h expected 1 40000004", ra_write, ra_data);
    end
    tick();
    checks++; if ({pc, state} !== {32'h4000_0400, 3'd0}) begin errors++; $display("[TB] FAIL jal_done: got pc=%h st=%0d expected 40000400 0", pc, state); end
  endtask

  task automatic test_branch();
    do_reset();
    goto_pc(32'h100);
    set_instr(6'b000100, 6'd0, 16'hFFFE, 26'd0, 32'd0);
    zero = 1'b0;
    tick();
    checks++; if ({pc, state} !== {32'h104, 3'd1}) begin errors++; $display("[TB] FAIL beq_if: got pc=%h st=%0d expected 104 1", pc, state); end
    tick();
    zero = 1'b1;
    #1;
    checks++; if (pc_write !== 1'b1) begin errors++; $display("[TB] FAIL beq_taken_pw: got %b expected 1", pc_write); end
    tick();
    zero = 1'b0;
    checks++; if ({pc, state} !== {32'h0FC, 3'd0}) begin errors++; $display("[TB] FAIL beq_taken: got pc=%h st=%0d expected 0fc 0", pc, state); end
    goto_pc(32'h100);
    set_instr(6'b000100, 6'd0, 16'hFFFE, 26'd0, 32'd0);
    zero = 1'b1;
    tick();
    tick();
    zero = 1'b0;
    #1;
    checks++; if (pc_write !== 1'b0) begin errors++; $display("[TB] FAIL beq_nt_pw: got %b expected 0", pc_write); end
    tick();
    checks++; if ({pc, state} !== {32'h104, 3'd0}) begin errors++; $display("[TB] FAIL beq_not_taken: got pc=%h st=%0d expected 104 0", pc, state); end
    goto_pc(32'h100);
    set_instr(6'b000101, 6'd0, 16'hFFFE, 26'd0, 32'd0);
    zero = 1'b1;
    tick();
    tick();
    zero = 1'b0;
    tick();
    checks++; if ({pc, state} !== {32'h0FC, 3'd0}) begin errors++; $display("[TB] FAIL bne_taken: got pc=%h st=%0d expected 0fc 0", pc, state); end
  endtask

  task automatic test_program();
    int cycles;
    logic [5:0]  ops [4];
    logic [5:0]  fns [4];
    int          lat [4];
    ops[0] = 6'b000000; fns[0] = 6'b100000; lat[0] = 4;
    ops[1] = 6'b100011; fns[1] = 6'b000000; lat[1] = 5;
    ops[2] = 6'b101011; fns[2] = 6'b000000; lat[2] = 4;
    ops[3] = 6'b000000; fns[3] = 6'b001000; lat[3] = 2;
    do_reset();
    imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_instr(ops[k], fns[k], 16'd0, 26'd0, 32'h20);
      cycles = 0;
      do begin
        tick();
        cycles++;
        // lw must walk IF-ID-EXE-MEM-WB in order
        if (k == 1 && cycles < 5) begin
          checks++; if (state !== 3'(cycles)) begin errors++; $display("[TB] FAIL lw_seq%0d: got st=%0d expected %0d", cycles, state, cycles); end
        end
      end while (state !== 3'd0 && cycles < 10);
      checks++; if (cycles != lat[k]) begin errors++; $display("[TB] FAIL prog_latency%0d: got %0d cycles expected %0d", k, cycles, lat[k]); end
    end
    checks++; if ({pc, retired} !== {32'h20, 32'd4}) begin errors++; $display("[TB] FAIL prog_final: got pc=%h ret=%0d expected 20 4", pc, retired); end
  endtask

  task automatic test_halt();
    do_reset();
    set_instr(6'b111111, 6'd0, 16'd0, 26'd0, 32'd0);
    imem_ready = 1'b1;
    tick();
    tick();
    checks++; if ({state, halted, fetch_req, ir_write, pc_write, ra_write} !== {3'd5, 5'b10000}) begin
      errors++; $display("[TB] FAIL halt_enter: got st=%0d h/fr/ir/pw/ra=%b expected 5 10000", state, {halted, fetch_req, ir_write, pc_write, ra_write});
    end
    checks++; if ({pc, retired} !== {32'h4, 32'd1}) begin errors++; $display("[TB] FAIL halt_regs: got pc=%h ret=%0d expected 4 1", pc, retired); end
    for (int i = 0; i < 4; i++) begin
      imem_ready = i[0];
      tick();
      checks++; if ({pc, state, fetch_req} !== {32'h4, 3'd5, 1'b0}) begin
        errors++; $display("[TB] FAIL halt_hold%0d: got pc=%h st=%0d fr=%b expected 4 5 0", i, pc, state, fetch_req);
      end
    end
    imem_ready = 1'b0;
    do_reset();
    checks++; if ({pc, state, retired, halted} !== {32'h0, 3'd0, 32'd0, 1'b0}) begin
      errors++; $display("[TB] FAIL halt_reset: got pc=%h st=%0d ret=%0d h=%b expected 0 0 0 0", pc, state, retired, halted);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    goto_pc(32'h100);
    set_instr(6'b000100, 6'd0, 16'hFFFE, 26'd0, 32'd0);
    zero = 1'b1;
    tick();
    tick();
    checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL rst_exe_setup: got st=%0d expected 2", state); end
    imem_ready = 1'b0;
    do_reset();
    #1;
    checks++; if ({pc, state, retired, pc_write, ra_write} !== {32'h0, 3'd0, 32'd0, 2'b00}) begin
      errors++; $display("[TB] FAIL rst_exe: got pc=%h st=%0d ret=%0d pw=%b ra=%b expected 0 0 0 0 0", pc, state, retired, pc_write, ra_write);
    end
    zero = 1'b0;
    set_instr(6'b100011, 6'd0, 16'd0, 26'd0, 32'd0);
    imem_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("[TB] FAIL rst_mem_setup: got st=%0d expected 3", state); end
    imem_ready = 1'b0;
    do_reset();
    #1;
    checks++; if ({pc, state, pc_write, ra_write} !== {32'h0, 3'd0, 2'b00}) begin
      errors++; $display("[TB] FAIL rst_mem: got pc=%h st=%0d pw=%b ra=%b expected 0 0 0 0", pc, state, pc_write, ra_write);
    end
    goto_pc(32'hFFFF_FFFC);
    set_instr(6'b000000, 6'b100000, 16'd0, 26'd0, 32'd0);
    tick();
    checks++; if ({pc, state} !== {32'h0, 3'd1}) begin errors++; $display("[TB] FAIL pc_wrap: got pc=%h st=%0d expected 0 1", pc, state); end
  endtask

  initial begin
    $display("[TB] pc_sequencer directed tests");
    test_reset();
    test_jump();
    test_branch();
    test_program();
    test_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
